sram_ws: RTL

Parametrised synchronous static-RAM model with a chip-select/read-write bus interface and configurable wait states. It generalises the lab 8k x 8 SRAM in width, depth and access timing. It adds byte enables, a ready handshake, abort on early chip-select release and out-of-range detection. It sits behind the lab bus master as the data memory for the SMP exercises.

---
 rtl/sram_ws.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sram_ws.sv
// Synchronous SRAM model with chip-select/read-write bus, byte enables and
// programmable wait states; one access per chip-select assertion.
module sram_ws #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 13,
  parameter int DEPTH       = 8192,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              rw_n,
  input  logic              oe_n,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_en,
  output logic              rdy,
  output logic              err
);

  localparam int              NB      = DATA_W / 8;
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WS_L    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_HOLD
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic              w_req;

  logic [ADDR_W-1:0] r_a;
  logic              r_rw_n;
  logic [NB-1:0]     r_be;
  logic [DATA_W-1:0] r_din;

  logic [DATA_W-1:0] r_dout;
  logic              r_rdy;
  logic              r_err;
  logic              r_rvld;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_oor;
  logic              w_do_write;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rdata;

  // Request stage: next-state logic; a release of cs_n in WAIT wins over the count
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!cs_n) begin
          w_req = 1'b1;
          if (WS_L == 4'd0) begin
            w_state_nxt = S_ACCESS;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = WS_L;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (cs_n) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == 4'd1) begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (cs_n) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_req) begin
      r_a    <= a;
      r_rw_n <= rw_n;
      r_be   <= be;
      r_din  <= din;
    end
  end

  // Access stage: index is narrowed to the array size; range is checked on the full address
  assign w_oor      = ({1'b0, r_a} >= DEPTH_L);
  assign w_idx      = r_a[IDX_W-1:0];
  assign w_rdata    = r_mem[w_idx];
  assign w_do_write = (r_state == S_ACCESS) && !r_rw_n && !w_oor;

  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int i = 0; i < NB; i++) begin
        if (r_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_din[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_dout  <= '0;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
      r_rvld  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
      if (r_state == S_ACCESS) begin
        r_rdy  <= 1'b1;
        r_err  <= w_oor;
        r_dout <= w_oor ? '0 : w_rdata;
        r_rvld <= r_rw_n & ~w_oor;
      end
    end
  end

  // Output stage
  assign dout    = r_dout;
  assign rdy     = r_rdy;
  assign err     = r_err;
  assign dout_en = ~oe_n & r_rvld;

endmodule
